piso_serializer: RTL

Parallel-in, serial-out transmitter that produces the single-bit, clock-sampled data stream consumed by the team's flip-flop and shift-register receivers. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock with a qualifying valid strobe. Back-to-back words stream with no gap. It sits upstream of any serial-in chain built from `d_flipflop` stages and replaces hand-written stimulus sequences with a synthesizable source.

---
 rtl/piso_pkg.sv | 32 +++
 rtl/piso_bit_counter.sv | 41 ++++
 rtl/piso_serializer.sv | 114 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding and frame sizing for piso_serializer.
//               Optional parity bit selected by macro PISO_PARITY_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package piso_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_t;

`ifdef PISO_PARITY_EN
    localparam bit c_parity_en = 1'b1;
`else
    localparam bit c_parity_en = 1'b0;
`endif

    function automatic int piso_frame_len(input int width);
        return c_parity_en ? width + 1 : width;
    endfunction

    function automatic int piso_cnt_width(input int frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_bit_counter.sv
// ============================================================================
// Module      : piso_bit_counter
// Description : Frame bit counter with a registered last-bit flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = piso_cnt_width(FRAME_LEN)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] c_pre_last = CNT_W'(FRAME_LEN - 2);

    logic [CNT_W-1:0] r_count;
    logic             r_last;

    // last is registered one count ahead so it lines up with the final bit
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
            r_last  <= (r_count == c_pre_last);
        end
    end

    assign last = r_last;

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter with valid/ready load.
//               Define PISO_PARITY_EN to append an even-parity bit per frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdata,
    output logic             sdata_valid,
    output logic             busy,
    output logic             done
);

    localparam int c_frame_len = piso_frame_len(WIDTH);

    piso_state_t            r_state;
    logic [c_frame_len-1:0] r_shreg;
    logic                   r_sdata;
    logic                   r_sdata_valid;
    logic                   r_busy;

    logic [c_frame_len-1:0] w_frame;
    logic [c_frame_len-1:0] w_load_rest;
    logic [c_frame_len-1:0] w_shift_rest;
    logic                   w_load_bit;
    logic                   w_shift_bit;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_shifting;

    // Frame word holds data plus optional parity, arranged so that the bit
    // leaving the shift register first is always the first frame bit.
    if (MSB_FIRST != 0) begin : g_msb_first
`ifdef PISO_PARITY_EN
        assign w_frame = {din, ^din};
`else
        assign w_frame = din;
`endif
        assign w_load_bit   = w_frame[c_frame_len-1];
        assign w_load_rest  = {w_frame[c_frame_len-2:0], 1'b0};
        assign w_shift_bit  = r_shreg[c_frame_len-1];
        assign w_shift_rest = {r_shreg[c_frame_len-2:0], 1'b0};
    end else begin : g_lsb_first
`ifdef PISO_PARITY_EN
        assign w_frame = {^din, din};
`else
        assign w_frame = din;
`endif
        assign w_load_bit   = w_frame[0];
        assign w_load_rest  = {1'b0, w_frame[c_frame_len-1:1]};
        assign w_shift_bit  = r_shreg[0];
        assign w_shift_rest = {1'b0, r_shreg[c_frame_len-1:1]};
    end

    assign w_shifting = (r_state == ST_SHIFT);
    assign load_ready = !rst && (!w_shifting || w_last);
    assign w_accept   = load_valid && load_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_sdata       <= 1'b0;
            r_sdata_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else if (w_accept) begin
            r_state       <= ST_SHIFT;
            r_shreg       <= w_load_rest;
            r_sdata       <= w_load_bit;
            r_sdata_valid <= 1'b1;
            r_busy        <= 1'b1;
        end else if (w_shifting) begin
            if (w_last) begin
                r_state       <= ST_IDLE;
                r_sdata       <= 1'b0;
                r_sdata_valid <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                r_shreg <= w_shift_rest;
                r_sdata <= w_shift_bit;
            end
        end
    end

    piso_bit_counter #(
        .FRAME_LEN (c_frame_len)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .en    (w_shifting),
        .last  (w_last)
    );

    assign sdata       = r_sdata;
    assign sdata_valid = r_sdata_valid;
    assign busy        = r_busy;
    assign done        = w_last;

endmodule

`default_nettype wire
